// File: rtl/code_seq_driver.sv
// Serial code sequencer: shifts a latched code word MSB-first onto D, DIV clocks per bit.
// Optional even-parity trailer bit when CODE_SEQ_PARITY_EN is defined.
module code_seq_driver #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV   = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Code,
  output logic             D,
  output logic             Bit_En,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned BW       = $clog2(WIDTH + 1);
  localparam logic [7:0]  DIV_LAST = 8'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
`ifdef CODE_SEQ_PARITY_EN
    PAR,
`endif
    SHIFT
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n;
  logic [BW-1:0]    bit_cnt, bit_n;
  logic [7:0]       div_cnt, div_n;
  logic             d_n, bit_en_n, busy_n, done_n;
`ifdef CODE_SEQ_PARITY_EN
  logic             par, par_n;
`endif

  always_comb begin
    state_n = state;
    sr_n    = sr;
    bit_n   = bit_cnt;
    div_n   = div_cnt;
    done_n  = 1'b0;
`ifdef CODE_SEQ_PARITY_EN
    par_n   = par;
`endif
    case (state)
      IDLE: begin
        if (Start) begin
          state_n = SHIFT;
          sr_n    = Code;
          bit_n   = BW'(WIDTH - 1);
          div_n   = DIV_LAST;
`ifdef CODE_SEQ_PARITY_EN
          par_n   = ^Code;
`endif
        end
      end
      SHIFT: begin
        if (div_cnt == 8'd0) begin
          if (bit_cnt != '0) begin
            sr_n  = sr << 1;
            div_n = DIV_LAST;
            bit_n = bit_cnt - 1'b1;
          end else begin
`ifdef CODE_SEQ_PARITY_EN
            state_n = PAR;
            div_n   = DIV_LAST;
`else
            state_n = IDLE;
            done_n  = 1'b1;
`endif
          end
        end else begin
          div_n = div_cnt - 8'd1;
        end
      end
`ifdef CODE_SEQ_PARITY_EN
      PAR: begin
        if (div_cnt == 8'd0) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          div_n = div_cnt - 8'd1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase

    // Outputs are computed from the next state so every output is a flop.
    case (state_n)
      SHIFT:   d_n = sr_n[WIDTH-1];
`ifdef CODE_SEQ_PARITY_EN
      PAR:     d_n = par_n;
`endif
      default: d_n = 1'b0;
    endcase
    busy_n   = (state_n != IDLE);
    bit_en_n = busy_n && (div_n == DIV_LAST);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      D       <= 1'b0;
      Bit_En  <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
`ifdef CODE_SEQ_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      sr      <= sr_n;
      bit_cnt <= bit_n;
      div_cnt <= div_n;
      D       <= d_n;
      Bit_En  <= bit_en_n;
      Busy    <= busy_n;
      Done    <= done_n;
`ifdef CODE_SEQ_PARITY_EN
      par     <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_code_seq_driver.sv
// Directed self-checking bench for code_seq_driver (DIV=4 and DIV=1 instances).
// Expectations follow CODE_SEQ_PARITY_EN when it is defined for the build.
module tb_code_seq_driver;

`ifdef CODE_SEQ_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0, Start1 = 1'b0;
  logic [3:0] Code = '0, Code1 = '0;
  logic       D, Bit_En, Busy, Done;
  logic       D1, Bit_En1, Busy1, Done1;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  code_seq_driver #(.WIDTH(4), .DIV(4)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Code(Code),
    .D(D), .Bit_En(Bit_En), .Busy(Busy), .Done(Done)
  );

  code_seq_driver #(.WIDTH(4), .DIV(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .Start(Start1), .Code(Code1),
    .D(D1), .Bit_En(Bit_En1), .Busy(Busy1), .Done(Done1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Expected serial bit i of a word: data MSB-first, then even parity.
  function automatic logic exp_bit(input logic [3:0] c, input int i);
    if (i < 4) return c[3 - i];
    return ^c;
  endfunction

  // Sends one word on the DIV=4 instance and checks every cycle through Done.
  // Leaves the bench in the Done cycle so a following call runs back-to-back.
  task automatic send4(input logic [3:0] c, input bit inject);
    Start = 1'b1;
    Code  = c;
    tick();
    Start = 1'b0;
    for (int k = 1; k <= NB * 4; k++) begin
      check($sformatf("d4_D_k%0d", k), D, exp_bit(c, (k - 1) / 4));
      check($sformatf("d4_ben_k%0d", k), Bit_En, ((k - 1) % 4) == 0);
      check($sformatf("d4_busy_k%0d", k), Busy, 1'b1);
      check($sformatf("d4_done_k%0d", k), Done, 1'b0);
      if (inject && k == 5) begin
        Start = 1'b1;
        Code  = 4'b0000;
      end else if (inject && k == 6) begin
        Start = 1'b0;
        Code  = c;
      end
      tick();
    end
    check("d4_done_pulse", Done, 1'b1);
    check("d4_done_busy", Busy, 1'b0);
    check("d4_done_D", D, 1'b0);
    check("d4_done_ben", Bit_En, 1'b0);
  endtask

  initial begin
    // Reset for 3 cycles, then idle must stay quiet
    Reset = 1'b1;
    repeat (3) tick();
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_D", D, 1'b0);
      check("rst_busy", Busy, 1'b0);
      check("rst_done", Done, 1'b0);
      check("rst_ben", Bit_En, 1'b0);
      check("rst_busy1", Busy1, 1'b0);
    end

    // Basic word with a Start during Busy (ignored), then back-to-back word
    send4(4'b1011, 1'b1);
    send4(4'b0110, 1'b0);
    tick();
    check("done_one_cycle", Done, 1'b0);
    check("idle_busy", Busy, 1'b0);
    repeat (3) tick();

    // DIV=1: one bit per clock
    Start1 = 1'b1;
    Code1  = 4'b1001;
    tick();
    Start1 = 1'b0;
    Code1  = 4'b1111;
    for (int k = 1; k <= NB; k++) begin
      check($sformatf("d1_D_k%0d", k), D1, exp_bit(4'b1001, k - 1));
      check($sformatf("d1_ben_k%0d", k), Bit_En1, 1'b1);
      check($sformatf("d1_busy_k%0d", k), Busy1, 1'b1);
      check($sformatf("d1_done_k%0d", k), Done1, 1'b0);
      tick();
    end
    check("d1_done", Done1, 1'b1);
    check("d1_done_busy", Busy1, 1'b0);
    check("d1_done_ben", Bit_En1, 1'b0);
    tick();
    check("d1_done_clear", Done1, 1'b0);

    // Mid-word reset: start at t, reset sampled at edge t+7
    Start = 1'b1;
    Code  = 4'b1011;
    tick();
    Start = 1'b0;
    repeat (6) tick();
    check("mid_busy_pre", Busy, 1'b1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("mid_D", D, 1'b0);
    check("mid_busy", Busy, 1'b0);
    check("mid_ben", Bit_En, 1'b0);
    check("mid_done", Done, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("mid_no_done", Done, 1'b0);
      check("mid_no_busy", Busy, 1'b0);
    end

    // Reset wins over Start on the same edge
    Reset = 1'b1;
    Start = 1'b1;
    Code  = 4'b1111;
    tick();
    Reset = 1'b0;
    Start = 1'b0;
    check("rst_prio_busy", Busy, 1'b0);
    check("rst_prio_D", D, 1'b0);
    tick();
    check("rst_prio_busy2", Busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
